reg_file_2r1w: RTL
==================

Name: reg_file_2r1w

Overview:
- Operand register file directly upstream of the bitwise logic units (AND/OR/XOR n-bit) in the ALU_REG datapath.
- Holds 2**addr_size general registers of word_size bits.
- Provides one synchronous write port and two registered read ports; the read ports drive the R2 and R3 operand buses consumed by the logic units.
- Register 0 is hard-wired to zero; simultaneous write/read to the same address forwards the new data.

Parameters:
word_size, 32, width of each register and of the R2/R3 operand buses
addr_size, 5, address width; register count = 2**addr_size

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
W_en  input  1  write enable
W_addr  input  addr_size  write address
W_data  input  word_size  write data
RD_en  input  1  read request; captures both read addresses this cycle
RA2_addr  input  addr_size  read address for operand R2
RA3_addr  input  addr_size  read address for operand R3
R2  output  word_size  registered read data, port 2 (feeds logic-unit input R2)
R3  output  word_size  registered read data, port 3 (feeds logic-unit input R3)
Rd_valid  output  1  high for exactly one cycle when R2/R3 carry data for a request

Behaviour:
- Reset: one clk edge with rst=1 clears every register to 0, R2=0, R3=0, Rd_valid=0. W_en and RD_en in that cycle are ignored. rst dominates all other inputs.
- Write: on an edge with W_en=1, rst=0, mem[W_addr] <= W_data. Writes to address 0 are discarded; mem[0] always reads 0.
- Read latency: exactly 1 cycle. RD_en=1 at edge N -> R2/R3 valid after edge N, and Rd_valid=1 in the following cycle.
- Rd_valid: equals RD_en registered. Back-to-back RD_en gives back-to-back valid results, one per cycle.
- Hold: when RD_en=0, R2/R3 hold their last value; Rd_valid=0.
- Bypass (write-first): RD_en=1 and W_en=1 at the same edge with RAx_addr==W_addr!=0 -> the Rx output shows W_data, not the old content. This applies independently per port and to both ports together.
- Address 0 read: returns 0 regardless of any concurrent write to 0; no bypass for address 0.
- Same address on both read ports: R2 and R3 receive identical data.
- No handshake back-pressure: the consumer must sample R2/R3 when Rd_valid=1.
- Widths: no arithmetic; all data paths are word_size wide. Addresses are used modulo 2**addr_size with no range check.
- Storage: flop array reset on rst. No RAM inference is required, because reset clears every entry.

Decomposition:
- Shared package: ALU_REG width constants (default word_size=32, addr_size=5) and the constant for the zero-register address (0).
- Natural sub-module: reg_read_port. It contains the address mux, the zero-register force and the write-first bypass compare, and outputs one word_size read value.
- reg_file_2r1w instantiates reg_read_port twice (ports 2 and 3) and owns the storage array, the R2/R3 output flops and the Rd_valid flop.

Test Plan:
1. Reset and zero register: apply rst=1 for 1 cycle, then RD_en=1 with RA2=3, RA3=0 -> R2=0, R3=0, Rd_valid=1 one cycle later. Then write W_addr=0, W_data=32'hDEADBEEF and read RA2=0 -> R2=0.
2. Basic write/read: write reg5=32'hF0F0_1234 and reg9=32'h0FF0_FFFF. Next cycle, RD_en=1, RA2=5, RA3=9 -> R2=F0F01234, R3=0FF0FFFF, Rd_valid pulses for 1 cycle. The downstream AND of these gives 00F01234.
3. Bypass: reg7=32'h11111111. In the same cycle, W_en=1, W_addr=7, W_data=32'hAAAA5555 and RD_en=1, RA2=7, RA3=7 -> R2=R3=AAAA5555. A later read of 7 also returns AAAA5555.
4. Hold and back-to-back: RD_en=1 for 3 consecutive cycles with RA2=1,2,3 (preloaded with 1,2,3) -> R2=1,2,3 on successive cycles with Rd_valid high for 3 cycles. Then RD_en=0 -> R2 holds 3 and Rd_valid=0.
5. Reset mid-operation: reg4=32'h12345678, then assert rst=1 in the same cycle as W_en=1 (W_addr=4, W_data=32'h55555555) and RD_en=1 (RA2=4) -> R2=0, Rd_valid=0. A subsequent read of 4 returns 0.
6. Address wrap and parameter override: with addr_size=3, word_size=8, write regs 1..7 with values 8'h11..8'h77 -> reads return the matching values, and reg0 reads 0.

Source files
------------

// File: rtl/reg_file_2r1w_pkg.sv
// Shared constants for the ALU_REG operand register file.
package reg_file_2r1w_pkg;

    // Default datapath widths of the ALU_REG operand path.
    localparam int WORD_SIZE = 32;
    localparam int ADDR_SIZE = 5;

    // Register 0 is the hard-wired zero register.
    localparam int ZERO_REG_ADDR = 0;

endpackage : reg_file_2r1w_pkg

// File: rtl/reg_file_2r1w_read_port.sv
// One combinational read path: address mux, write-first bypass, zero-register force.
module reg_read_port
    import reg_file_2r1w_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int addr_size = ADDR_SIZE
) (
    input  logic [addr_size-1:0] rd_addr,
    input  logic [word_size-1:0] mem [2**addr_size],
    input  logic                 w_en,
    input  logic [addr_size-1:0] w_addr,
    input  logic [word_size-1:0] w_data,
    output logic [word_size-1:0] rd_data
);

    logic is_zero;

    assign is_zero = (rd_addr == addr_size'(ZERO_REG_ADDR));

    // Select stored word; a same-edge write to this address wins, register 0 always reads 0.
    always_comb begin
        rd_data = mem[rd_addr];
        if (w_en && (w_addr == rd_addr)) begin
            rd_data = w_data;
        end
        if (is_zero) begin
            rd_data = '0;
        end
    end

endmodule : reg_read_port

// File: rtl/reg_file_2r1w.sv
// Two-read / one-write operand register file feeding the R2/R3 logic-unit buses.
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int word_size = WORD_SIZE,
    parameter int addr_size = ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 W_en,
    input  logic [addr_size-1:0] W_addr,
    input  logic [word_size-1:0] W_data,
    input  logic                 RD_en,
    input  logic [addr_size-1:0] RA2_addr,
    input  logic [addr_size-1:0] RA3_addr,
    output logic [word_size-1:0] R2,
    output logic [word_size-1:0] R3,
    output logic                 Rd_valid
);

    localparam int depth = 2**addr_size;

    logic [word_size-1:0] mem_reg [depth];
    logic [addr_size-1:0] rd_addr [2];
    logic [word_size-1:0] rd_data [2];
    logic [word_size-1:0] r2_reg;
    logic [word_size-1:0] r3_reg;
    logic                 rd_valid_reg;
    logic                 wr_ok;

    // Writes to the zero register are dropped so entry 0 stays cleared.
    assign wr_ok = W_en && (W_addr != addr_size'(ZERO_REG_ADDR));

    assign rd_addr[0] = RA2_addr;
    assign rd_addr[1] = RA3_addr;

    // Index 0 drives the R2 path, index 1 the R3 path.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            reg_read_port #(
                .word_size (word_size),
                .addr_size (addr_size)
            ) u_port (
                .rd_addr (rd_addr[gi]),
                .mem     (mem_reg),
                .w_en    (W_en),
                .w_addr  (W_addr),
                .w_data  (W_data),
                .rd_data (rd_data[gi])
            );
        end
    endgenerate

    // Storage array: cleared on reset, otherwise one write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < depth; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_reg[W_addr] <= W_data;
        end
    end

    // Operand output flops: load on a read request, otherwise hold; valid follows RD_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_reg       <= '0;
            r3_reg       <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= RD_en;
            if (RD_en) begin
                r2_reg <= rd_data[0];
                r3_reg <= rd_data[1];
            end
        end
    end

    assign R2       = r2_reg;
    assign R3       = r3_reg;
    assign Rd_valid = rd_valid_reg;

endmodule : reg_file_2r1w
